// File: rtl/fdiv_iq_pkg.sv
// Shared types and helpers for the FP divide/sqrt issue queue.
// Entry layout plus the wrap-aware ROB age comparison.
package fdiv_iq_pkg;

  localparam int FDIV_IQ_DEPTH = 4;
  localparam int FDIV_ROB_W    = 6;
  localparam int FDIV_PREG_W   = 7;
  localparam int FDIV_WK_NUM   = 4;

  typedef struct packed {
    logic [FDIV_ROB_W-1:0]  robIdx;
    logic [FDIV_PREG_W-1:0] rd;
    logic [FDIV_PREG_W-1:0] rs1;
    logic [FDIV_PREG_W-1:0] rs2;
    logic                   rs1_rdy;
    logic                   rs2_rdy;
    logic                   div;
    logic                   db;
    logic [2:0]             rm;
  } FDivIQEntry;

  // a strictly older than b; MSB is the ROB wrap bit
  function automatic logic loop_older(
    input logic [FDIV_ROB_W-1:0] a,
    input logic [FDIV_ROB_W-1:0] b
  );
    logic [FDIV_ROB_W-2:0] av;
    logic [FDIV_ROB_W-2:0] bv;
    av = a[FDIV_ROB_W-2:0];
    bv = b[FDIV_ROB_W-2:0];
    if (a[FDIV_ROB_W-1] == b[FDIV_ROB_W-1])
      return av < bv;
    return av > bv;
  endfunction

endpackage

// File: rtl/fdiv_iq_age_matrix.sv
// Age matrix for the fdiv issue queue.
// Row i holds the entries older than entry i; picks the oldest candidate.
module fdiv_iq_age_matrix
  import fdiv_iq_pkg::*;
#(
  parameter int DEPTH = FDIV_IQ_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] enq_oh,
  input  logic [DEPTH-1:0] row_init,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] cand,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] age_q [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      oldest[i] = cand[i] & ~|(age_q[i] & cand);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++)
          if (free[j]) age_q[i][j] <= 1'b0;
        if (enq_oh[i]) age_q[i] <= row_init;
      end
    end
  end

endmodule

// File: rtl/fdiv_issue_queue.sv
// Age-ordered issue queue feeding the single-op FP divide/sqrt unit.
// Tracks operand wakeups, issues oldest ready op, handles redirects.
module fdiv_issue_queue
  import fdiv_iq_pkg::*;
#(
  parameter int DEPTH      = FDIV_IQ_DEPTH,
  parameter int ROB_WIDTH  = FDIV_ROB_W,
  parameter int PREG_WIDTH = FDIV_PREG_W,
  parameter int WAKEUP_NUM = FDIV_WK_NUM
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  logic [ROB_WIDTH-1:0]           enq_robIdx,
  input  logic [PREG_WIDTH-1:0]          enq_rd,
  input  logic [PREG_WIDTH-1:0]          enq_rs1,
  input  logic [PREG_WIDTH-1:0]          enq_rs2,
  input  logic                           enq_rs1_rdy,
  input  logic                           enq_rs2_rdy,
  input  logic                           enq_div,
  input  logic                           enq_db,
  input  logic [2:0]                     enq_rm,
  input  logic [WAKEUP_NUM-1:0]          wk_en,
  input  logic [WAKEUP_NUM*PREG_WIDTH-1:0] wk_rd,
  output logic                           issue_en,
  output logic [ROB_WIDTH-1:0]           issue_robIdx,
  output logic [PREG_WIDTH-1:0]          issue_rd,
  output logic [PREG_WIDTH-1:0]          issue_rs1,
  output logic [PREG_WIDTH-1:0]          issue_rs2,
  output logic                           issue_div,
  output logic                           issue_db,
  output logic [2:0]                     issue_rm,
  input  logic                           fu_done,
  input  logic                           redirect,
  input  logic [ROB_WIDTH-1:0]           redirect_idx
);

  FDivIQEntry       ent_q [DEPTH];
  FDivIQEntry       sel_ent;
  FDivIQEntry       enq_ent;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] oldest;
  logic [DEPTH-1:0] sel_oh;
  logic [DEPTH-1:0] freed;
  logic [DEPTH-1:0] enq_oh;
  logic [DEPTH-1:0] enq_wr;
  logic [DEPTH-1:0] rs1_wk;
  logic [DEPTH-1:0] rs2_wk;
  logic             busy_q;
  logic             sel_any;
  logic             found;
  logic             enq_fire;
  logic             inflight_kill;

  function automatic logic woken(
    input logic [PREG_WIDTH-1:0]            p,
    input logic [WAKEUP_NUM-1:0]            en,
    input logic [WAKEUP_NUM*PREG_WIDTH-1:0] rd
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKEUP_NUM; k++)
      if (en[k] && rd[k*PREG_WIDTH +: PREG_WIDTH] == p)
        hit = 1'b1;
    return hit;
  endfunction

  assign enq_ready = ~&valid_q;

  always_comb begin
    flush  = '0;
    cand   = '0;
    rs1_wk = '0;
    rs2_wk = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush[i] = redirect & valid_q[i]
               & ~loop_older(ent_q[i].robIdx, redirect_idx);
      cand[i]  = valid_q[i] & ent_q[i].rs1_rdy
               & ent_q[i].rs2_rdy & ~flush[i];
      rs1_wk[i] = woken(ent_q[i].rs1, wk_en, wk_rd);
      rs2_wk[i] = woken(ent_q[i].rs2, wk_en, wk_rd);
    end
  end

  // the unit takes a new op on the same cycle it drains the old one
  always_comb begin
    sel_oh  = (~busy_q | fu_done) ? oldest : '0;
    sel_any = |sel_oh;
    freed   = flush | sel_oh;
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i]) sel_ent = ent_q[i];
  end

  always_comb begin
    enq_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (!valid_q[i] && !found) begin
        enq_oh[i] = 1'b1;
        found     = 1'b1;
      end
    enq_fire = enq_valid & enq_ready
             & ~(redirect & ~loop_older(enq_robIdx, redirect_idx));
    enq_wr = enq_fire ? enq_oh : '0;
    enq_ent.robIdx  = enq_robIdx;
    enq_ent.rd      = enq_rd;
    enq_ent.rs1     = enq_rs1;
    enq_ent.rs2     = enq_rs2;
    enq_ent.rs1_rdy = enq_rs1_rdy | woken(enq_rs1, wk_en, wk_rd);
    enq_ent.rs2_rdy = ~enq_div | enq_rs2_rdy
                    | woken(enq_rs2, wk_en, wk_rd);
    enq_ent.div     = enq_div;
    enq_ent.db      = enq_db;
    enq_ent.rm      = enq_rm;
  end

  assign inflight_kill = redirect & busy_q
                       & ~loop_older(issue_robIdx, redirect_idx);

  fdiv_iq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk      (clk),
    .rst      (rst),
    .enq_oh   (enq_wr),
    .row_init (valid_q & ~freed),
    .free     (freed),
    .cand     (cand),
    .oldest   (oldest)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      busy_q       <= 1'b0;
      issue_en     <= 1'b0;
      issue_robIdx <= '0;
      issue_rd     <= '0;
      issue_rs1    <= '0;
      issue_rs2    <= '0;
      issue_div    <= 1'b0;
      issue_db     <= 1'b0;
      issue_rm     <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (freed[i]) begin
          valid_q[i] <= 1'b0;
        end else begin
          if (rs1_wk[i]) ent_q[i].rs1_rdy <= 1'b1;
          if (rs2_wk[i]) ent_q[i].rs2_rdy <= 1'b1;
        end
        if (enq_wr[i]) begin
          valid_q[i] <= 1'b1;
          ent_q[i]   <= enq_ent;
        end
      end
      issue_en <= sel_any;
      if (sel_any) begin
        issue_robIdx <= sel_ent.robIdx;
        issue_rd     <= sel_ent.rd;
        issue_rs1    <= sel_ent.rs1;
        issue_rs2    <= sel_ent.rs2;
        issue_div    <= sel_ent.div;
        issue_db     <= sel_ent.db;
        issue_rm     <= sel_ent.rm;
      end
      if (sel_any)
        busy_q <= 1'b1;
      else if (fu_done | inflight_kill)
        busy_q <= 1'b0;
    end
  end

endmodule
